// File: rtl/minima_mc_core_if.sv
// Instruction-fetch and data-memory bus of the MiniMA multi-cycle core.
// The core drives the master side; ROM and data memory sit on the slave side.
interface minima_mc_core_if #(
  parameter int W   = 8,
  parameter int PCW = 12,
  parameter int IW  = 9
) ();
  logic [PCW-1:0] imem_addr;
  logic [IW-1:0]  imem_data;
  logic           dmem_req;
  logic           dmem_we;
  logic [W-1:0]   dmem_addr;
  logic [W-1:0]   dmem_wdata;
  logic [W-1:0]   dmem_rdata;
  logic           dmem_ack;

  modport master (
    output imem_addr, input imem_data,
    output dmem_req, output dmem_we, output dmem_addr, output dmem_wdata,
    input  dmem_rdata, input dmem_ack
  );

  modport slave (
    input  imem_addr, output imem_data,
    input  dmem_req, input dmem_we, input dmem_addr, input dmem_wdata,
    output dmem_rdata, output dmem_ack
  );
endinterface

// File: rtl/minima_mc_core.sv
// MiniMA multi-cycle core: FETCH/EXEC/MEM/HALT sequencer, 8-opcode ISA,
// req/ack data memory with wait states, flags and saturating retire counter.
module minima_mc_core #(
  parameter int W   = 8,
  parameter int PCW = 12,
  parameter int RA  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  minima_mc_core_if.master  bus,
  output logic              done,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic [15:0]       instret
);
  localparam int IW = 3 + 2 * RA;
  localparam int NR = 1 << RA;
  localparam logic [PCW-1:0] PC_ONE = {{(PCW-1){1'b0}}, 1'b1};

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_LDI = 3'd4;
  localparam logic [2:0] OP_LD  = 3'd5;
  localparam logic [2:0] OP_ST  = 3'd6;
  localparam logic [2:0] OP_BR  = 3'd7;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  state_t          state_r, state_s;
  logic [W-1:0]    regs_r [NR];
  logic [PCW-1:0]  pc_r, pc_next_s;
  logic [IW-1:0]   ir_r;
  logic            z_r, c_r, done_r;
  logic [15:0]     instret_r;
  logic            dmem_req_r, dmem_we_r;
  logic [W-1:0]    dmem_addr_r, dmem_wdata_r;

  logic [2:0]      op_s;
  logic [RA-1:0]   a_s, b_s;
  logic [W-1:0]    ra_val_s, rb_val_s;
  logic [W:0]      sum_s, diff_s;
  logic [W-1:0]    alu_res_s, wb_data_s;
  logic            alu_c_s, is_halt_s;
  logic [PCW-1:0]  boff_s;
  logic            wb_en_s, flag_upd_s, retire_s, mem_start_s;

  assign op_s      = ir_r[IW-1 -: 3];
  assign a_s       = ir_r[2*RA-1:RA];
  assign b_s       = ir_r[RA-1:0];
  assign ra_val_s  = regs_r[a_s];
  assign rb_val_s  = regs_r[b_s];
  assign is_halt_s = (a_s == {RA{1'b0}}) && (b_s == {RA{1'b0}});
  assign boff_s    = {{(PCW-RA){b_s[RA-1]}}, b_s};

  assign bus.imem_addr  = pc_r;
  assign bus.dmem_req   = dmem_req_r;
  assign bus.dmem_we    = dmem_we_r;
  assign bus.dmem_addr  = dmem_addr_r;
  assign bus.dmem_wdata = dmem_wdata_r;
  assign done           = done_r;
  assign zero_flag      = z_r;
  assign carry_flag     = c_r;
  assign instret        = instret_r;

  // ALU result and carry; SUB carry is the unsigned borrow
  always_comb begin
    sum_s     = {1'b0, ra_val_s} + {1'b0, rb_val_s};
    diff_s    = {1'b0, ra_val_s} - {1'b0, rb_val_s};
    alu_res_s = sum_s[W-1:0];
    alu_c_s   = c_r;
    case (op_s)
      OP_ADD: begin alu_res_s = sum_s[W-1:0];  alu_c_s = sum_s[W];  end
      OP_SUB: begin alu_res_s = diff_s[W-1:0]; alu_c_s = diff_s[W]; end
      OP_AND: alu_res_s = ra_val_s & rb_val_s;
      OP_XOR: alu_res_s = ra_val_s ^ rb_val_s;
      default: alu_res_s = sum_s[W-1:0];
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_FETCH;
    else        state_r <= state_s;
  end

  // Next state and per-cycle datapath strobes
  always_comb begin
    state_s     = state_r;
    pc_next_s   = pc_r;
    wb_en_s     = 1'b0;
    wb_data_s   = {W{1'b0}};
    flag_upd_s  = 1'b0;
    retire_s    = 1'b0;
    mem_start_s = 1'b0;
    case (state_r)
      S_FETCH: state_s = S_EXEC;
      S_EXEC: begin
        case (op_s)
          OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
            wb_en_s = 1'b1; wb_data_s = alu_res_s; flag_upd_s = 1'b1;
            pc_next_s = pc_r + PC_ONE; retire_s = 1'b1; state_s = S_FETCH;
          end
          OP_LDI: begin
            wb_en_s = 1'b1; wb_data_s = {{(W-RA){1'b0}}, b_s};
            pc_next_s = pc_r + PC_ONE; retire_s = 1'b1; state_s = S_FETCH;
          end
          OP_LD, OP_ST: begin
            mem_start_s = 1'b1; state_s = S_MEM;
          end
          OP_BR: begin
            retire_s = 1'b1;
            if (is_halt_s) begin
              state_s = S_HALT;
            end else begin
              state_s = S_FETCH;
              if (ra_val_s != {W{1'b0}}) pc_next_s = pc_r + boff_s;
              else                       pc_next_s = pc_r + PC_ONE;
            end
          end
          default: state_s = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          wb_en_s = ~dmem_we_r; wb_data_s = bus.dmem_rdata;
          pc_next_s = pc_r + PC_ONE; retire_s = 1'b1; state_s = S_FETCH;
        end else begin
          state_s = S_MEM;
        end
      end
      S_HALT: state_s = S_HALT;
      default: state_s = S_FETCH;
    endcase
  end

  // Architectural state, flags, retire counter and memory request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) regs_r[i] <= {W{1'b0}};
      pc_r         <= {PCW{1'b0}};
      ir_r         <= {IW{1'b0}};
      z_r          <= 1'b0;
      c_r          <= 1'b0;
      done_r       <= 1'b0;
      instret_r    <= 16'h0000;
      dmem_req_r   <= 1'b0;
      dmem_we_r    <= 1'b0;
      dmem_addr_r  <= {W{1'b0}};
      dmem_wdata_r <= {W{1'b0}};
    end else begin
      if (state_r == S_FETCH) ir_r <= bus.imem_data;
      if (wb_en_s) regs_r[a_s] <= wb_data_s;
      pc_r   <= pc_next_s;
      done_r <= (state_s == S_HALT);
      if (flag_upd_s) begin
        z_r <= (alu_res_s == {W{1'b0}});
        c_r <= alu_c_s;
      end
      if (retire_s && (instret_r != 16'hFFFF)) instret_r <= instret_r + 16'd1;
      // Address and store data are frozen at EXEC so they stay stable across wait states
      if (mem_start_s) begin
        dmem_req_r   <= 1'b1;
        dmem_we_r    <= (op_s == OP_ST);
        dmem_addr_r  <= rb_val_s;
        dmem_wdata_r <= ra_val_s;
      end else if ((state_r == S_MEM) && bus.dmem_ack) begin
        dmem_req_r <= 1'b0;
        dmem_we_r  <= 1'b0;
      end
    end
  end
endmodule
